// File: rtl/pc_sequencer_pkg.sv
// Shared front-end constants for the next-PC sequencer.
// Address width, reset vector and FSM state encodings.
package pc_sequencer_pkg;

    localparam int ADDR_BUS_WIDTH = 32;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC00000;

    typedef enum logic {
        PC_STATE_RUN  = 1'b0,
        PC_STATE_SLOT = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational next-PC priority mux over exception, mispredict,
// pending redirect, delay-slot target, predictor and sequential PC.
module pc_redirect_sel #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  exc_valid,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    input  logic                  mis_valid,
    input  logic [ADDR_WIDTH-1:0] mis_pc,
    input  logic                  pend_valid,
    input  logic [ADDR_WIDTH-1:0] pend_pc,
    input  logic                  pend_is_exc,
    input  logic                  in_slot,
    input  logic [ADDR_WIDTH-1:0] slot_target,
    input  logic                  bp_taken,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  slot_next,
    output logic                  load_slot,
    output logic                  pend_set,
    output logic [ADDR_WIDTH-1:0] pend_pc_new,
    output logic                  pend_exc_new
);

    logic                  redirect_req;
    logic [ADDR_WIDTH-1:0] redir_pc;
    logic [ADDR_WIDTH-1:0] seq_pc;

    assign redirect_req = exc_valid | mis_valid;
    assign redir_pc     = exc_valid ? exc_pc : mis_pc;
    assign seq_pc       = pc + ADDR_WIDTH'(4);

    always_comb begin
        next_pc   = seq_pc;
        slot_next = 1'b0;
        load_slot = 1'b0;
        priority case (1'b1)
            redirect_req: next_pc = redir_pc;
            pend_valid:   next_pc = pend_pc;
            in_slot:      next_pc = slot_target;
            bp_taken: begin
                next_pc   = seq_pc;
                slot_next = 1'b1;
                load_slot = 1'b1;
            end
            default: ;
        endcase
    end

    // A pending exception must not be displaced by a wrong-path mispredict.
    assign pend_set = exc_valid
                    | (mis_valid & ~(pend_valid & pend_is_exc));
    assign pend_pc_new  = redir_pc;
    assign pend_exc_new = exc_valid;

endmodule

// File: rtl/pc_sequencer.sv
// Front-end next-PC generator: drives the fetch PC, its valid and
// the PC/BP register flush, honouring the branch delay slot.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_BUS_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  exc_valid,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    input  logic                  mis_valid,
    input  logic [ADDR_WIDTH-1:0] mis_pc,
    input  logic                  bp_taken,
    input  logic [ADDR_WIDTH-1:0] bp_target,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  pc_valid_out,
    output logic                  flush_out
);

    pc_state_e state_q;
    pc_state_e state_d;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  pc_valid_q;
    logic [ADDR_WIDTH-1:0] slot_target;
    logic                  pend_valid;
    logic [ADDR_WIDTH-1:0] pend_pc;
    logic                  pend_is_exc;

    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  slot_next;
    logic                  load_slot;
    logic                  pend_set;
    logic [ADDR_WIDTH-1:0] pend_pc_new;
    logic                  pend_exc_new;
    logic                  advance;

    // The first post-reset cycle presents RESET_PC before advancing.
    assign advance = ~stall & pc_valid_q;

    pc_redirect_sel #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_sel (
        .exc_valid    (exc_valid),
        .exc_pc       (exc_pc),
        .mis_valid    (mis_valid),
        .mis_pc       (mis_pc),
        .pend_valid   (pend_valid),
        .pend_pc      (pend_pc),
        .pend_is_exc  (pend_is_exc),
        .in_slot      (state_q == PC_STATE_SLOT),
        .slot_target  (slot_target),
        .bp_taken     (bp_taken),
        .pc           (pc_q),
        .next_pc      (next_pc),
        .slot_next    (slot_next),
        .load_slot    (load_slot),
        .pend_set     (pend_set),
        .pend_pc_new  (pend_pc_new),
        .pend_exc_new (pend_exc_new)
    );

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = slot_next ? PC_STATE_SLOT : PC_STATE_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PC_STATE_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
        end else begin
            pc_valid_q <= 1'b1;
            if (advance) begin
                pc_q <= next_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_target <= '0;
        end else if (advance && load_slot) begin
            slot_target <= bp_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_pc     <= '0;
            pend_is_exc <= 1'b0;
        end else if (advance) begin
            pend_valid <= 1'b0;
        end else if (pend_set) begin
            pend_valid  <= 1'b1;
            pend_pc     <= pend_pc_new;
            pend_is_exc <= pend_exc_new;
        end
    end

    assign pc_out       = pc_q;
    assign pc_valid_out = pc_valid_q;
    assign flush_out    = (exc_valid | mis_valid) & ~rst;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed per-cycle vectors push
// expected pc/valid/flush; a negedge monitor pops and compares.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        mis_valid;
    logic [31:0] mis_pc;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic [31:0] pc_out;
    logic        pc_valid_out;
    logic        flush_out;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic        valid;
        logic        flush;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   cyc_n;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .exc_valid    (exc_valid),
        .exc_pc       (exc_pc),
        .mis_valid    (mis_valid),
        .mis_pc       (mis_pc),
        .bp_taken     (bp_taken),
        .bp_target    (bp_target),
        .pc_out       (pc_out),
        .pc_valid_out (pc_valid_out),
        .flush_out    (flush_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (pc_out !== e.pc || pc_valid_out !== e.valid
                || flush_out !== e.flush) begin
                errors++;
                $display("FAIL cyc%0d: pc=%h valid=%b flush=%b, expected pc=%h valid=%b flush=%b",
                         e.idx, pc_out, pc_valid_out, flush_out,
                         e.pc, e.valid, e.flush);
            end
        end
    end

    task automatic cyc(
        input logic        r,
        input logic        st,
        input logic        ev,
        input logic [31:0] ep,
        input logic        mv,
        input logic [31:0] mp,
        input logic        bt,
        input logic [31:0] btg,
        input logic [31:0] xpc,
        input logic        xv,
        input logic        xf
    );
        exp_t e;
        rst       = r;
        stall     = st;
        exc_valid = ev;
        exc_pc    = ep;
        mis_valid = mv;
        mis_pc    = mp;
        bp_taken  = bt;
        bp_target = btg;
        e.idx   = cyc_n;
        e.pc    = xpc;
        e.valid = xv;
        e.flush = xf;
        sb.push_back(e);
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc_n  = 0;
        rst = 1'b1; stall = 1'b0;
        exc_valid = 1'b0; exc_pc = '0;
        mis_valid = 1'b0; mis_pc = '0;
        bp_taken = 1'b0; bp_target = '0;
        @(posedge clk);
        #1;
        //  rst st ev exc_pc        mv mis_pc        bt bp_target     exp_pc        v  f
        // reset, flush masked by rst
        cyc(1, 0, 1, 32'hBFC00380, 0, 32'h0,        0, 32'h0,        32'hBFC00000, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hBFC00000, 0, 0);
        // free run
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hBFC00000, 1, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hBFC00004, 1, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hBFC00008, 1, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hBFC0000C, 1, 0);
        // predicted-taken branch with delay slot; bp ignored in SLOT
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hBFC00100, 32'hBFC00010, 1, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hDEAD0000, 32'hBFC00014, 1, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hBFC00100, 1, 0);
        // exception beats mispredict
        cyc(0, 0, 1, 32'hBFC00380, 1, 32'h80001000, 0, 32'h0,        32'hBFC00104, 1, 1);
        // redirect cancels delay-slot target
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80000500, 32'hBFC00380, 1, 0);
        cyc(0, 0, 0, 32'h0,        1, 32'h80002000, 0, 32'h0,        32'hBFC00384, 1, 1);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h80002000, 1, 0);
        // stall: exc pending, later mispredict must not displace it
        cyc(0, 1, 1, 32'hBFC00380, 0, 32'h0,        0, 32'h0,        32'h80002004, 1, 1);
        cyc(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h11111110, 32'h80002004, 1, 0);
        cyc(0, 1, 0, 32'h0,        1, 32'h80003000, 0, 32'h0,        32'h80002004, 1, 1);
        cyc(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h80002004, 1, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h80002004, 1, 0);
        // pending redirect cancels SLOT
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80000800, 32'hBFC00380, 1, 0);
        cyc(0, 1, 0, 32'h0,        1, 32'h80004000, 0, 32'h0,        32'hBFC00384, 1, 1);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hBFC00384, 1, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h80004000, 1, 0);
        // later exception overwrites pending mispredict
        cyc(0, 1, 0, 32'h0,        1, 32'h80005000, 0, 32'h0,        32'h80004004, 1, 1);
        cyc(0, 1, 1, 32'hBFC00200, 0, 32'h0,        0, 32'h0,        32'h80004004, 1, 1);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h80004004, 1, 0);
        // wrap-around
        cyc(0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0,        32'hBFC00200, 1, 1);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hFFFFFFFC, 1, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h00000000, 1, 0);
        // reset during stall with pending redirect
        cyc(0, 1, 0, 32'h0,        1, 32'h80006000, 0, 32'h0,        32'h00000004, 1, 1);
        cyc(1, 1, 0, 32'h0,        1, 32'h80007000, 0, 32'h0,        32'h00000004, 1, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hBFC00000, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hBFC00000, 1, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hBFC00004, 1, 0);
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
